// File: rtl/dmi_pkg.sv
// dmi_pkg: definitions shared by the DMI initiator and the debug module.
//   - DMI request op codes and response/sticky status codes
//   - initiator FSM state encoding
//   - DM register word addresses
package dmi_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    STAT_SUCCESS = 2'd0,
    STAT_FAILED  = 2'd2,
    STAT_BUSY    = 2'd3
  } dmi_stat_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [6:0] DM_DMCONTROL = 7'h10;
  localparam logic [6:0] DM_DMSTATUS  = 7'h11;
  localparam logic [6:0] DM_HARTINFO  = 7'h12;
  localparam logic [6:0] DM_NEXTDM    = 7'h1d;
  localparam logic [6:0] DM_PROGBUF0  = 7'h20;
  localparam logic [6:0] DM_PROGBUF1  = 7'h21;
  localparam logic [6:0] DM_HALTSUM0  = 7'h40;

endpackage

// File: rtl/dmi_wb_initiator.sv
// dmi_wb_initiator: turns DMI requests from a debug transport into single
// Wishbone classic transactions toward the debug module, and returns one
// response per request with sticky (JTAG-DTM style) error status.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_*                    DMI request (valid/ready, op, word addr, data)
//   rsp_*                    DMI response (valid/ready, status op, read data)
//   dmistat_o                sticky status
//   dmi_reset_i              clears sticky status
//   dmi_hardreset_i          aborts FSM/bus, clears sticky, keeps read data
//   dm_wb_*                  Wishbone classic initiator port
//
// state | meaning
// IDLE  | ready for a request, req_ready_o=1
// BUS   | Wishbone cycle in flight, waiting for ack/err or timeout
// RESP  | response presented, waiting for rsp_ready_i
module dmi_wb_initiator
  import dmi_pkg::*;
#(
  parameter int DMI_ABITS      = 7,
  parameter int DMI_DATAW      = 32,
  parameter int WB_ADDRW       = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [DMI_ABITS-1:0]   req_addr_i,
  input  logic [DMI_DATAW-1:0]   req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [1:0]             rsp_op_o,
  output logic [DMI_DATAW-1:0]   rsp_data_o,
  output logic [1:0]             dmistat_o,
  input  logic                   dmi_reset_i,
  input  logic                   dmi_hardreset_i,
  output logic [WB_ADDRW-1:0]    dm_wb_adr_o,
  output logic [DMI_DATAW-1:0]   dm_wb_dat_o,
  input  logic [DMI_DATAW-1:0]   dm_wb_dat_i,
  output logic                   dm_wb_cyc_o,
  output logic                   dm_wb_stb_o,
  output logic                   dm_wb_we_o,
  output logic [DMI_DATAW/8-1:0] dm_wb_sel_o,
  input  logic                   dm_wb_ack_i,
  input  logic                   dm_wb_err_i
);

  // A zero timeout still needs a 1-bit counter to keep the declaration legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]           r_state;
  logic                 r_cyc;
  logic                 r_we;
  logic [DMI_ABITS-1:0] r_addr;
  logic [DMI_DATAW-1:0] r_wdata;
  logic [DMI_DATAW-1:0] r_rdata;
  logic [1:0]           r_sticky;
  logic [1:0]           r_rsp_op;
  logic [CNT_W-1:0]     r_cnt;

  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_timeout;
  logic                 w_idle_req;
  logic                 w_rsvd_err;
  logic                 w_bus_err;
  logic                 w_set_err;
  logic                 w_rd_capture;
  logic [WB_ADDRW-1:0]  w_adr;

  // Saturating increment; the timeout fires on the cycle the count would
  // reach TIMEOUT_CYCLES, so BUS lasts exactly TIMEOUT_CYCLES cycles.
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_MAX);

  assign w_idle_req = (r_state == ST_IDLE) && req_valid_i;
  assign w_rsvd_err = w_idle_req && (r_sticky == STAT_SUCCESS) && (req_op_i == OP_RSVD);
  // err beats ack; ack beats a timeout landing on the same cycle.
  assign w_bus_err  = (r_state == ST_BUS) &&
                      (dm_wb_err_i || (!dm_wb_ack_i && w_timeout));
  assign w_set_err  = w_rsvd_err || w_bus_err;

  assign w_rd_capture = (r_state == ST_BUS) && dm_wb_ack_i && !dm_wb_err_i && !r_we;

  always_comb begin
    w_adr = '0;
    w_adr[DMI_ABITS+1:2] = r_addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || dmi_hardreset_i) begin
      r_state  <= ST_IDLE;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sticky <= STAT_SUCCESS;
      r_rsp_op <= STAT_SUCCESS;
      r_cnt    <= '0;
    end else begin
      // A new error outranks a simultaneous dmi_reset_i.
      if (w_set_err) begin
        r_sticky <= STAT_FAILED;
      end else if (dmi_reset_i) begin
        r_sticky <= STAT_SUCCESS;
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (r_sticky != STAT_SUCCESS) begin
              r_rsp_op <= r_sticky;
              r_state  <= ST_RESP;
            end else if (req_op_i == OP_NOP) begin
              r_rsp_op <= STAT_SUCCESS;
              r_state  <= ST_RESP;
            end else if (req_op_i == OP_RSVD) begin
              r_rsp_op <= STAT_FAILED;
              r_state  <= ST_RESP;
            end else begin
              r_addr  <= req_addr_i;
              r_wdata <= req_data_i;
              r_we    <= (req_op_i == OP_WRITE);
              r_cnt   <= '0;
              r_cyc   <= 1'b1;
              r_state <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (dm_wb_err_i) begin
            r_rsp_op <= STAT_FAILED;
            r_cyc    <= 1'b0;
            r_state  <= ST_RESP;
          end else if (dm_wb_ack_i) begin
            r_rsp_op <= STAT_SUCCESS;
            r_cyc    <= 1'b0;
            r_state  <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_op <= STAT_FAILED;
            r_cyc    <= 1'b0;
            r_state  <= ST_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

  // Read data survives dmi_hardreset_i; only a full reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (!dmi_hardreset_i && w_rd_capture) begin
      r_rdata <= dm_wb_dat_i;
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_op_o    = r_rsp_op;
  assign rsp_data_o  = r_rdata;
  assign dmistat_o   = r_sticky;

  assign dm_wb_adr_o = w_adr;
  assign dm_wb_dat_o = r_wdata;
  assign dm_wb_cyc_o = r_cyc;
  assign dm_wb_stb_o = r_cyc;
  assign dm_wb_we_o  = r_we;
  assign dm_wb_sel_o = r_cyc ? '1 : '0;

endmodule

// File: tb/tb_dmi_wb_initiator.sv
module tb_dmi_wb_initiator;

  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_data;
  logic [1:0]  dmistat;
  logic        dmi_reset, dmi_hardreset;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [3:0]  wb_sel;

  int          n_err = 0;
  int          n_chk = 0;
  int          slave_mode = 0;   // 0 ack, 1 silent, 2 err+ack together
  logic [31:0] slave_rdata = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  always #5 clk = ~clk;

  dmi_wb_initiator #(
    .DMI_ABITS(7), .DMI_DATAW(32), .WB_ADDRW(32), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_op_o(rsp_op), .rsp_data_o(rsp_data), .dmistat_o(dmistat),
    .dmi_reset_i(dmi_reset), .dmi_hardreset_i(dmi_hardreset),
    .dm_wb_adr_o(wb_adr), .dm_wb_dat_o(wb_dat_o), .dm_wb_dat_i(wb_dat_i),
    .dm_wb_cyc_o(wb_cyc), .dm_wb_stb_o(wb_stb), .dm_wb_we_o(wb_we),
    .dm_wb_sel_o(wb_sel), .dm_wb_ack_i(wb_ack), .dm_wb_err_i(wb_err)
  );

  // Registered slave: single-cycle ack/err one cycle after stb.
  assign wb_dat_i = slave_rdata;
  always @(posedge clk) begin
    wb_ack <= 1'b0;
    wb_err <= 1'b0;
    if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
      if (slave_mode == 0) wb_ack <= 1'b1;
      else if (slave_mode == 2) begin
        wb_ack <= 1'b1;
        wb_err <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got op=%0d data=%h expected no response", rsp_op, rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_op", 32'(rsp_op), 32'(e.op));
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
  endtask

  // Returns #1 after the accepting clock edge.
  task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                      input bit exp_rsp, input logic [1:0] eop, input logic [31:0] edata);
    int n;
    rsp_t e;
    @(posedge clk); #1;
    if (exp_rsp) begin
      e.op = eop;
      e.data = edata;
      sb.push_back(e);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'd0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: got req_ready=0 expected 1 within 100 cycles");
    end
  endtask

  // Counts negedges with cyc high until a response appears.
  task automatic count_bus(output int cnt);
    int k;
    cnt = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (wb_cyc) cnt++;
    end while (!rsp_valid && k < 100);
  endtask

  task automatic pulse_dmi_reset();
    @(posedge clk); #1;
    dmi_reset = 1'b1;
    @(posedge clk); #1;
    dmi_reset = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [1:0]  hold_op;
    logic [31:0] hold_data;
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b1; dmi_reset = 1'b0; dmi_hardreset = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fork monitor(); join_none

    // reset state
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cyc_stb_we_sel", {25'd0, wb_cyc, wb_stb, wb_we, wb_sel}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_dmistat", 32'(dmistat), 32'd0);

    // read DMSTATUS, with latency
    slave_mode = 0;
    slave_rdata = 32'h0040_0C82;
    send(2'd1, 7'h11, 32'h0, 1'b1, 2'd0, 32'h0040_0C82);
    @(negedge clk);
    check("rd_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd3);
    check("rd_adr", wb_adr, 32'h44);
    check("rd_we", 32'(wb_we), 32'd0);
    check("rd_sel", 32'(wb_sel), 32'hF);
    check("rd_rsp_valid_t1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_rsp_valid_t2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_rsp_valid_t3", 32'(rsp_valid), 32'd1);
    wait_idle();

    // write DMCONTROL
    send(2'd2, 7'h10, 32'h0000_0001, 1'b1, 2'd0, 32'h0040_0C82);
    @(negedge clk);
    check("wr_adr", wb_adr, 32'h40);
    check("wr_we", 32'(wb_we), 32'd1);
    check("wr_dat", wb_dat_o, 32'h1);
    wait_idle();

    // nop: no bus cycle
    send(2'd0, 7'h00, 32'h0, 1'b1, 2'd0, 32'h0040_0C82);
    count_bus(cnt);
    check("nop_bus_cycles", 32'(cnt), 32'd0);
    wait_idle();

    // timeout
    slave_mode = 1;
    send(2'd1, 7'h12, 32'h0, 1'b1, 2'd2, 32'h0040_0C82);
    count_bus(cnt);
    check("timeout_bus_cycles", 32'(cnt), 32'(TOUT));
    wait_idle();
    check("timeout_dmistat", 32'(dmistat), 32'd2);

    // sticky failure: no bus cycle
    slave_mode = 0;
    send(2'd1, 7'h11, 32'h0, 1'b1, 2'd2, 32'h0040_0C82);
    count_bus(cnt);
    check("sticky_bus_cycles", 32'(cnt), 32'd0);
    wait_idle();

    // dmi_reset then a good read
    pulse_dmi_reset();
    @(negedge clk);
    check("dmireset_dmistat", 32'(dmistat), 32'd0);
    slave_rdata = 32'h1234_5678;
    send(2'd1, 7'h11, 32'h0, 1'b1, 2'd0, 32'h1234_5678);
    wait_idle();

    // reserved op
    send(2'd3, 7'h20, 32'h0, 1'b1, 2'd2, 32'h1234_5678);
    count_bus(cnt);
    check("rsvd_bus_cycles", 32'(cnt), 32'd0);
    wait_idle();
    check("rsvd_dmistat", 32'(dmistat), 32'd2);
    pulse_dmi_reset();

    // err+ack together while dmi_reset_i is held: set wins
    slave_mode = 2;
    slave_rdata = 32'hDEAD_BEEF;
    dmi_reset = 1'b1;
    send(2'd1, 7'h11, 32'h0, 1'b1, 2'd2, 32'h1234_5678);
    count_bus(cnt);
    dmi_reset = 1'b0;
    check("err_dmistat", 32'(dmistat), 32'd2);
    wait_idle();
    pulse_dmi_reset();

    // response backpressure
    slave_mode = 0;
    slave_rdata = 32'hCAFE_F00D;
    rsp_ready = 1'b0;
    send(2'd1, 7'h40, 32'h0, 1'b1, 2'd0, 32'hCAFE_F00D);
    count_bus(cnt);
    hold_op = rsp_op;
    hold_data = rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, req_ready, 28'd0, rsp_op}, {1'b1, 1'b0, 28'd0, hold_op});
      check("bp_data", rsp_data, hold_data);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);

    // hardreset clears sticky
    send(2'd3, 7'h00, 32'h0, 1'b1, 2'd2, 32'hCAFE_F00D);
    wait_idle();
    @(posedge clk); #1 dmi_hardreset = 1'b1;
    @(posedge clk); #1 dmi_hardreset = 1'b0;
    @(negedge clk);
    check("hrst_idle_dmistat", 32'(dmistat), 32'd0);

    // hardreset during BUS
    slave_mode = 1;
    send(2'd1, 7'h11, 32'h0, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    check("hrst_bus_active", 32'(wb_cyc), 32'd1);
    @(posedge clk); #1 dmi_hardreset = 1'b1;
    @(posedge clk); #1 dmi_hardreset = 1'b0;
    @(negedge clk);
    check("hrst_drop", {28'd0, wb_cyc, wb_stb, rsp_valid, req_ready}, 32'd1);
    check("hrst_dmistat", 32'(dmistat), 32'd0);
    check("hrst_data_kept", rsp_data, 32'hCAFE_F00D);

    // rst_i during BUS
    send(2'd1, 7'h11, 32'h0, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    check("rst_bus_active", 32'(wb_cyc), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_drop", {28'd0, wb_cyc, wb_stb, rsp_valid, req_ready}, 32'd1);
    check("rst_data_cleared", rsp_data, 32'd0);
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
